// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: payload layout, feedback layout,
// per-edge action encoding and the bubble payload.
package ex_mem_pkg;

  localparam int EM_N_REG      = 32;
  localparam int EM_N_REG_ADDR = 5;
  localparam int EM_MEMOP_W    = 8;
  localparam int EM_CNT_W      = 2;

  localparam logic [EM_MEMOP_W-1:0]    MEMOP_NOP    = '0;
  localparam logic [EM_N_REG_ADDR-1:0] NOP_REG_ADDR = '0;

  typedef struct packed {
    logic                     valid;
    logic                     wen;
    logic [EM_N_REG_ADDR-1:0] waddr;
    logic [EM_N_REG-1:0]      wdata;
    logic                     hilo_wen;
    logic [EM_N_REG-1:0]      hi;
    logic [EM_N_REG-1:0]      lo;
    logic [EM_MEMOP_W-1:0]    memop;
    logic [EM_N_REG-1:0]      mem_addr;
    logic [EM_N_REG-1:0]      mem_sdata;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [2*EM_N_REG-1:0] hilo_temp;
    logic [EM_CNT_W-1:0]   cnt;
  } ex_fb_t;

  typedef enum logic [1:0] {ACT_ADVANCE, ACT_HOLD, ACT_BUBBLE, ACT_FLUSH} stage_act_e;

  function automatic ex_mem_payload_t bubble_payload();
    ex_mem_payload_t p;
    p       = '0;
    p.waddr = NOP_REG_ADDR;
    p.memop = MEMOP_NOP;
    return p;
  endfunction

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall/flush control, valid bit, memory-op fields,
// the EX multi-cycle feedback register and a saturating bubble counter.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int N_REG      = EM_N_REG,
  parameter int N_REG_ADDR = EM_N_REG_ADDR,
  parameter int MEMOP_W    = EM_MEMOP_W,
  parameter int CNT_W      = EM_CNT_W,
  parameter int PERF_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall_ex,
  input  logic                  i_stall_mem,
  input  logic                  i_flush,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_wen,
  input  logic [N_REG_ADDR-1:0] i_ex_waddr,
  input  logic [N_REG-1:0]      i_ex_wdata,
  input  logic                  i_ex_hilo_wen,
  input  logic [N_REG-1:0]      i_ex_hi,
  input  logic [N_REG-1:0]      i_ex_lo,
  input  logic [MEMOP_W-1:0]    i_ex_memop,
  input  logic [N_REG-1:0]      i_ex_mem_addr,
  input  logic [N_REG-1:0]      i_ex_mem_sdata,
  input  logic [2*N_REG-1:0]    i_ex_hilo_temp,
  input  logic [CNT_W-1:0]      i_ex_cnt,
  output logic                  o_mem_valid,
  output logic                  o_mem_wen,
  output logic [N_REG_ADDR-1:0] o_mem_waddr,
  output logic [N_REG-1:0]      o_mem_wdata,
  output logic                  o_mem_hilo_wen,
  output logic [N_REG-1:0]      o_mem_hi,
  output logic [N_REG-1:0]      o_mem_lo,
  output logic [MEMOP_W-1:0]    o_mem_memop,
  output logic [N_REG-1:0]      o_mem_mem_addr,
  output logic [N_REG-1:0]      o_mem_mem_sdata,
  output logic [2*N_REG-1:0]    o_ex_hilo_temp,
  output logic [CNT_W-1:0]      o_ex_cnt,
  output logic [PERF_W-1:0]     o_bubble_cnt
);

  stage_act_e      act;
  ex_mem_payload_t ex_payload;
  ex_mem_payload_t payload_q;
  ex_fb_t          ex_fb;
  ex_fb_t          fb_q;

  // The illegal vector (MEM stalled, EX not) falls through to HOLD.
  always_comb begin
    act = ACT_ADVANCE;
    if (i_flush)                         act = ACT_FLUSH;
    else if (i_stall_ex && !i_stall_mem) act = ACT_BUBBLE;
    else if (i_stall_ex || i_stall_mem)  act = ACT_HOLD;
  end

  always_comb begin
    ex_payload           = '0;
    ex_payload.valid     = i_ex_valid;
    ex_payload.wen       = i_ex_wen;
    ex_payload.waddr     = i_ex_waddr;
    ex_payload.wdata     = i_ex_wdata;
    ex_payload.hilo_wen  = i_ex_hilo_wen;
    ex_payload.hi        = i_ex_hi;
    ex_payload.lo        = i_ex_lo;
    ex_payload.memop     = i_ex_memop;
    ex_payload.mem_addr  = i_ex_mem_addr;
    ex_payload.mem_sdata = i_ex_mem_sdata;
    ex_fb                = '0;
    ex_fb.hilo_temp      = i_ex_hilo_temp;
    ex_fb.cnt            = i_ex_cnt;
  end

  // The feedback loop only survives BUBBLE/HOLD; leaving EX or a flush abandons it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      payload_q <= bubble_payload();
      fb_q      <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          payload_q <= bubble_payload();
          fb_q      <= '0;
        end
        ACT_BUBBLE: begin
          payload_q <= bubble_payload();
          fb_q      <= ex_fb;
        end
        ACT_ADVANCE: begin
          payload_q <= ex_payload;
          fb_q      <= '0;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_inc (act == ACT_BUBBLE),
    .o_cnt (o_bubble_cnt)
  );

  assign o_mem_valid     = payload_q.valid;
  assign o_mem_wen       = payload_q.wen;
  assign o_mem_waddr     = payload_q.waddr;
  assign o_mem_wdata     = payload_q.wdata;
  assign o_mem_hilo_wen  = payload_q.hilo_wen;
  assign o_mem_hi        = payload_q.hi;
  assign o_mem_lo        = payload_q.lo;
  assign o_mem_memop     = payload_q.memop;
  assign o_mem_mem_addr  = payload_q.mem_addr;
  assign o_mem_mem_sdata = payload_q.mem_sdata;
  assign o_ex_hilo_temp  = fb_q.hilo_temp;
  assign o_ex_cnt        = fb_q.cnt;

  a_stall_monotone: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_stall_mem && !i_stall_ex));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a rule-level model of the EX->MEM register.
module tb_ex_mem_stage;

  localparam int PW   = 4;
  localparam int PLW  = 176;
  localparam int BMAX = (1 << PW) - 1;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall_ex, i_stall_mem, i_flush;
  logic        i_ex_valid, i_ex_wen, i_ex_hilo_wen;
  logic [4:0]  i_ex_waddr;
  logic [31:0] i_ex_wdata, i_ex_hi, i_ex_lo, i_ex_mem_addr, i_ex_mem_sdata;
  logic [7:0]  i_ex_memop;
  logic [63:0] i_ex_hilo_temp;
  logic [1:0]  i_ex_cnt;
  logic        o_mem_valid, o_mem_wen, o_mem_hilo_wen;
  logic [4:0]  o_mem_waddr;
  logic [31:0] o_mem_wdata, o_mem_hi, o_mem_lo, o_mem_mem_addr, o_mem_mem_sdata;
  logic [7:0]  o_mem_memop;
  logic [63:0] o_ex_hilo_temp;
  logic [1:0]  o_ex_cnt;
  logic [PW-1:0] o_bubble_cnt;

  ex_mem_stage #(.PERF_W(PW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall_ex(i_stall_ex), .i_stall_mem(i_stall_mem),
    .i_flush(i_flush), .i_ex_valid(i_ex_valid), .i_ex_wen(i_ex_wen), .i_ex_waddr(i_ex_waddr),
    .i_ex_wdata(i_ex_wdata), .i_ex_hilo_wen(i_ex_hilo_wen), .i_ex_hi(i_ex_hi), .i_ex_lo(i_ex_lo),
    .i_ex_memop(i_ex_memop), .i_ex_mem_addr(i_ex_mem_addr), .i_ex_mem_sdata(i_ex_mem_sdata),
    .i_ex_hilo_temp(i_ex_hilo_temp), .i_ex_cnt(i_ex_cnt),
    .o_mem_valid(o_mem_valid), .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr),
    .o_mem_wdata(o_mem_wdata), .o_mem_hilo_wen(o_mem_hilo_wen), .o_mem_hi(o_mem_hi),
    .o_mem_lo(o_mem_lo), .o_mem_memop(o_mem_memop), .o_mem_mem_addr(o_mem_mem_addr),
    .o_mem_mem_sdata(o_mem_mem_sdata), .o_ex_hilo_temp(o_ex_hilo_temp), .o_ex_cnt(o_ex_cnt),
    .o_bubble_cnt(o_bubble_cnt)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard / model ----------------
  logic [PLW-1:0] exp_q[$];
  logic [PLW-1:0] m_pay;
  logic [63:0]    m_hilo;
  logic [1:0]     m_cnt;
  int             m_bcnt;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Next state from the stage rules: reset > flush > bubble > hold > advance.
  task automatic predict();
    if (i_rst) begin
      m_pay = '0; m_hilo = '0; m_cnt = '0; m_bcnt = 0;
    end else if (i_flush) begin
      m_pay = '0; m_hilo = '0; m_cnt = '0;
    end else if (i_stall_ex && !i_stall_mem) begin
      m_pay  = '0;
      m_hilo = i_ex_hilo_temp;
      m_cnt  = i_ex_cnt;
      m_bcnt = (m_bcnt < BMAX) ? m_bcnt + 1 : BMAX;
    end else if (!i_stall_ex && !i_stall_mem) begin
      m_pay  = {i_ex_valid, i_ex_wen, i_ex_waddr, i_ex_wdata, i_ex_hilo_wen, i_ex_hi,
                i_ex_lo, i_ex_memop, i_ex_mem_addr, i_ex_mem_sdata};
      m_hilo = '0;
      m_cnt  = '0;
    end
    exp_q.push_back(m_pay);
  endtask

  task automatic compare_all();
    logic [PLW-1:0] e;
    logic        e_valid, e_wen, e_hwen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_hi, e_lo, e_addr, e_sdata;
    logic [7:0]  e_memop;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    {e_valid, e_wen, e_waddr, e_wdata, e_hwen, e_hi, e_lo, e_memop, e_addr, e_sdata} = e;
    check("valid",     64'(o_mem_valid),     64'(e_valid));
    check("wen",       64'(o_mem_wen),       64'(e_wen));
    check("waddr",     64'(o_mem_waddr),     64'(e_waddr));
    check("wdata",     64'(o_mem_wdata),     64'(e_wdata));
    check("hilo_wen",  64'(o_mem_hilo_wen),  64'(e_hwen));
    check("hi",        64'(o_mem_hi),        64'(e_hi));
    check("lo",        64'(o_mem_lo),        64'(e_lo));
    check("memop",     64'(o_mem_memop),     64'(e_memop));
    check("mem_addr",  64'(o_mem_mem_addr),  64'(e_addr));
    check("mem_sdata", 64'(o_mem_mem_sdata), 64'(e_sdata));
    check("hilo_temp", o_ex_hilo_temp,       m_hilo);
    check("ex_cnt",    64'(o_ex_cnt),        64'(m_cnt));
    check("bubble_cnt", 64'(o_bubble_cnt),   64'(m_bcnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    predict();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic rand_ex();
    i_ex_valid     = 1'($urandom_range(0, 1));
    i_ex_wen       = 1'($urandom_range(0, 1));
    i_ex_waddr     = 5'($urandom_range(0, 31));
    i_ex_wdata     = $urandom;
    i_ex_hilo_wen  = 1'($urandom_range(0, 1));
    i_ex_hi        = $urandom;
    i_ex_lo        = $urandom;
    i_ex_memop     = 8'($urandom_range(0, 255));
    i_ex_mem_addr  = $urandom;
    i_ex_mem_sdata = $urandom;
    i_ex_hilo_temp = {$urandom, $urandom};
    i_ex_cnt       = 2'($urandom_range(0, 3));
  endtask

  task automatic set_ctl(input logic rst, input logic fl, input logic sx, input logic sm);
    i_rst = rst; i_flush = fl; i_stall_ex = sx; i_stall_mem = sm;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_pay = '0; m_hilo = '0; m_cnt = '0; m_bcnt = 0;
    rand_ex();
    set_ctl(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));

    // Reset for two cycles with random payload
    repeat (2) begin rand_ex(); step(); end

    // Plain advance
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_ex();
    i_ex_valid = 1'b1; i_ex_wen = 1'b1; i_ex_waddr = 5'd5; i_ex_wdata = 32'hDEADBEEF;
    step();
    check("adv_wdata", 64'(o_mem_wdata), 64'hDEADBEEF);

    // MADD loop: two bubbles feeding the partial result back
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    i_ex_cnt = 2'd1; i_ex_hilo_temp = 64'h1_0000_0002;
    step();
    i_ex_cnt = 2'd2; i_ex_hilo_temp = 64'h3_0000_0004;
    step();
    check("madd_bcnt", 64'(o_bubble_cnt), 64'd2);
    check("madd_temp", o_ex_hilo_temp, 64'h3_0000_0004);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_ex();
    step();

    // Hold for three cycles with changing inputs
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    i_ex_cnt = 2'd3;
    step();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin rand_ex(); step(); end

    // Flush beats the stall and abandons the multi-cycle op
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
    i_ex_cnt = 2'd1;
    step();
    check("flush_cnt", 64'(o_ex_cnt), 64'd0);

    // Saturation of the bubble counter
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) begin rand_ex(); step(); end
    check("sat_bcnt", 64'(o_bubble_cnt), 64'(BMAX));

    // Reset in the middle of a stall
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    rand_ex();
    step();

    // Random traffic with legal stall vectors only
    for (int i = 0; i < 400; i++) begin
      logic sx;
      sx = ($urandom_range(0, 9) < 4);
      set_ctl(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0), sx,
              sx && ($urandom_range(0, 1) == 1));
      rand_ex();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
